mult_arbiter: RTL and testbench

//  Shares one sequential shift-add multiplier between two ALU requesters (port 0, port 1).

---
 rtl/mult_arbiter_pkg.sv | 20 ++
 rtl/mult_arbiter_if.sv | 32 +++
 rtl/mult_arbiter_rr_arbiter_2.sv | 32 +++
 rtl/mult_arbiter.sv | 158 +++++++++++++++
 tb/tb_mult_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arbiter_pkg.sv
// Package mult_arb_pkg: shared definitions for the multiplier arbiter slice.
//   - state_t     : arbiter FSM state encoding (IDLE..DONE)
//   - DEF_WIDTH   : default operand width (product is 2*DEF_WIDTH)
//   - DEF_TIMEOUT : default cycle budget for ARM+WAIT before a transaction aborts
package mult_arb_pkg;

    localparam int DEF_WIDTH   = 3;
    localparam int DEF_TIMEOUT = 31;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_ARM    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SETTLE = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Interface mult_arbiter_if: requester handshakes plus the multiplier-side bus.
// Handshake: reqN is raised with aN/bN stable and held until validN pulses;
// gntN is high from the grant until the valid cycle; validN (and err on a
// timeout) is a one-cycle pulse with result valid in that same cycle.
//   modport slave  : the arbiter (drives gnt/valid/result/err and mult_mr/md/init)
//   modport master : the requesters and the multiplier (drive req/a/b and mult_res/done)
interface mult_arbiter_if #(
    parameter int WIDTH = mult_arb_pkg::DEF_WIDTH
);
    logic                 req0, req1;
    logic [WIDTH-1:0]     a0, a1;
    logic [WIDTH-1:0]     b0, b1;
    logic                 gnt0, gnt1;
    logic                 valid0, valid1;
    logic [2*WIDTH-1:0]   result;
    logic                 err;
    logic [WIDTH-1:0]     mult_mr;
    logic [WIDTH-1:0]     mult_md;
    logic                 mult_init;
    logic [2*WIDTH-1:0]   mult_res;
    logic                 mult_done;

    modport slave (
        input  req0, req1, a0, a1, b0, b1, mult_res, mult_done,
        output gnt0, gnt1, valid0, valid1, result, err, mult_mr, mult_md, mult_init
    );

    modport master (
        output req0, req1, a0, a1, b0, b1, mult_res, mult_done,
        input  gnt0, gnt1, valid0, valid1, result, err, mult_mr, mult_md, mult_init
    );
endinterface

// File: rtl/mult_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant selection.
//   clk, rst_n     : clock, synchronous active-low reset
//   req0, req1     : pending requests
//   update, served : when update is high, served is recorded as the last-served port
//   any_req        : at least one request pending
//   grant          : port chosen (0/1); meaningful only when any_req is high
// On a tie the port that was not served last wins; after reset port 0 is favoured.
module rr_arbiter_2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic served,
    output logic any_req,
    output logic grant
);
    logic last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;   // pretend port 1 went last so port 0 wins the first tie
        end else if (update) begin
            last_q <= served;
        end
    end

    always_comb begin
        any_req = req0 | req1;
        grant   = (req0 && req1) ? ~last_q : req1;
    end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one sequential shift-add multiplier between two requesters.
//   clk       : clock, all logic on posedge
//   rst_n     : synchronous active-low reset (aborts any transaction, no valid)
//   bus       : mult_arbiter_if.slave (req/a/b/gnt/valid/result/err and mult_* signals)
//   dbg_state : current FSM state
// Optional feature macro MULT_BYPASS_EN: a zero operand skips the multiplier and
// completes with result 0 one cycle after the grant.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_arbiter_if.slave      bus,
    output state_t             dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    state_t               state_q, state_d;
    logic                 port_q;
    logic [WIDTH-1:0]     opa_q, opb_q, mr_q, md_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 err_q;
    logic [CW-1:0]        cnt_q;

    logic                 any_req, win, bypass;
    logic [WIDTH-1:0]     win_a, win_b;
    logic                 gnt0, gnt1, valid0, valid1, err, init;

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (bus.req0),
        .req1    (bus.req1),
        .update  (state_q == ST_DONE),
        .served  (port_q),
        .any_req (any_req),
        .grant   (win)
    );

    assign win_a = win ? bus.a1 : bus.a0;
    assign win_b = win ? bus.b1 : bus.b0;

`ifdef MULT_BYPASS_EN
    assign bypass = (win_a == '0) || (win_b == '0);
`else
    assign bypass = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_req) state_d = bypass ? ST_DONE : ST_PRIME;
            ST_PRIME:  state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_ARM;
            ST_ARM:    state_d = ST_WAIT;  // done here is left over from the previous run
            ST_WAIT: begin
                if (bus.mult_done)        state_d = ST_SETTLE;
                else if (cnt_q == TO_MAX) state_d = ST_DONE;
            end
            ST_SETTLE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Operand, multiplier-drive, timeout and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            port_q   <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            mr_q     <= '0;
            md_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        port_q <= win;
                        opa_q  <= win_a;
                        opb_q  <= win_b;
                        err_q  <= 1'b0;
                        if (bypass) begin
                            result_q <= '0;
                        end else begin
                            // Inverted operands during PRIME guarantee the multiplier
                            // sees an operand change even for a repeated request.
                            mr_q <= ~win_b;
                            md_q <= ~win_a;
                        end
                    end
                end
                ST_PRIME: begin
                    mr_q <= opb_q;
                    md_q <= opa_q;
                end
                ST_LOAD: cnt_q <= '0;
                ST_ARM:  cnt_q <= cnt_q + 1'b1;
                ST_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!bus.mult_done && cnt_q == TO_MAX) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end
                end
                ST_SETTLE: result_q <= bus.mult_res;
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        err    = 1'b0;
        init   = 1'b0;
        if (state_q != ST_IDLE) begin
            gnt0 = ~port_q;
            gnt1 = port_q;
        end
        if (state_q == ST_LOAD) init = 1'b1;
        if (state_q == ST_DONE) begin
            valid0 = ~port_q;
            valid1 = port_q;
            err    = err_q;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.valid0    = valid0;
    assign bus.valid1    = valid1;
    assign bus.err       = err;
    assign bus.result    = result_q;
    assign bus.mult_mr   = mr_q;
    assign bus.mult_md   = md_q;
    assign bus.mult_init = init;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: directed scenarios plus random traffic, with a
// behavioural multiplier and a queue-based scoreboard checked by a monitor.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int WIDTH   = 3;
    localparam int TIMEOUT = 31;
    localparam int RW      = 2 * WIDTH;
    localparam int EW      = 3 + RW;   // {init_expected, err, port, result}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_arbiter_if #(.WIDTH(WIDTH)) bus ();
    state_t dbg_state;

    mult_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural multiplier ----------------
    logic [RW-1:0] m_res, m_prod;
    logic          m_done;
    logic          m_busy, m_clr, m_pend;
    int            m_cnt;
    bit            stuck = 1'b0;

    assign bus.mult_res  = m_res;
    assign bus.mult_done = m_done;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_res <= '0; m_prod <= '0; m_done <= 1'b0;
            m_busy <= 1'b0; m_clr <= 1'b0; m_pend <= 1'b0; m_cnt <= 0;
        end else begin
            m_clr  <= bus.mult_init;
            m_pend <= 1'b0;
            if (m_clr) m_done <= 1'b0;          // old done lingers one cycle after init
            if (m_pend) m_res <= m_prod;        // product appears one cycle after done
            if (bus.mult_init) begin
                m_busy <= 1'b1;
                m_cnt  <= $urandom_range(2, 8);
                m_prod <= RW'(int'(bus.mult_mr) * int'(bus.mult_md));
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    if (!stuck) begin
                        m_done <= 1'b1;
                        m_pend <= 1'b1;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [EW-1:0]      exp_q[$];
    logic [2*WIDTH-1:0] op_q[$];     // {a, b} of each expected transaction, in order
    bit                 last_served = 1'b1;
    int                 init_cnt = 0;

    function automatic logic [EW-1:0] expect_word(input bit p, input int a, input int b);
        bit zero, init, e;
        int prod;
        zero = (a == 0) || (b == 0);
`ifdef MULT_BYPASS_EN
        init = !zero;
`else
        init = 1'b1;
`endif
        e    = stuck && init;
        prod = e ? 0 : a * b;
        return {init, e, p, RW'(prod)};
    endfunction

    task automatic push_exp(input bit p, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_q.push_back(expect_word(p, int'(a), int'(b)));
        op_q.push_back({a, b});
    endtask

    // ---------------- monitor ----------------
    logic [EW-1:0]    mon_e;
    logic [WIDTH-1:0] mon_a, mon_b, mon_na, mon_nb, prev_mr, prev_md;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mult_init) begin
                init_cnt++;
                check("op_queue_on_init", op_q.size() != 0, 1);
                if (op_q.size() != 0) begin
                    {mon_a, mon_b} = op_q[0];
                    mon_na = ~mon_a;
                    mon_nb = ~mon_b;
                    check("load_mr", bus.mult_mr, mon_b);
                    check("load_md", bus.mult_md, mon_a);
                    check("prime_mr", prev_mr, mon_nb);
                    check("prime_md", prev_md, mon_na);
                end
            end
            if (bus.valid0 || bus.valid1 || bus.err) begin
                check("valid_count", 32'(bus.valid0) + 32'(bus.valid1), 1);
                check("queue_on_valid", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    void'(op_q.pop_front());
                    check("port", bus.valid1, mon_e[RW]);
                    check("result", bus.result, mon_e[RW-1:0]);
                    check("err", bus.err, mon_e[RW+1]);
                    check("init_pulses", init_cnt, mon_e[RW+2]);
                    check("gnt_at_valid", {bus.gnt1, bus.gnt0}, {mon_e[RW], ~mon_e[RW]});
                end
                init_cnt = 0;
            end
        end
        prev_mr = bus.mult_mr;
        prev_md = bus.mult_md;
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_gnt_valid_err_init"},
              {bus.gnt0, bus.gnt1, bus.valid0, bus.valid1, bus.err, bus.mult_init}, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_mr_md"}, {bus.mult_mr, bus.mult_md}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        exp_q.delete();
        op_q.delete();
        last_served = 1'b1;
        init_cnt = 0;
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input bit w0, input bit w1, input int budget, output int cycles);
        bit need0, need1;
        int n;
        need0 = w0;
        need1 = w1;
        n = 0;
        while ((need0 || need1) && n < budget) begin
            @(negedge clk);
            n++;
            if (need0 && bus.valid0) begin need0 = 1'b0; bus.req0 = 1'b0; end
            if (need1 && bus.valid1) begin need1 = 1'b0; bus.req1 = 1'b0; end
        end
        check("completion_within_budget", {need0, need1}, 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        cycles = n;
    endtask

    task automatic run_single(input bit p, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              output int lat);
        @(negedge clk);
        push_exp(p, a, b);
        last_served = p;
        if (p) begin bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1; end
        else   begin bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1; end
        wait_done(!p, p, 200, lat);
    endtask

    task automatic run_pair(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                            input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
        bit first;
        int lat;
        @(negedge clk);
        first = ~last_served;          // on a tie the port not served last goes first
        if (first) begin push_exp(1, a1, b1); push_exp(0, a0, b0); end
        else       begin push_exp(0, a0, b0); push_exp(1, a1, b1); end
        last_served = ~first;
        bus.a0 = a0; bus.b0 = b0; bus.req0 = 1'b1;
        bus.a1 = a1; bus.b1 = b1; bus.req1 = 1'b1;
        wait_done(1'b1, 1'b1, 400, lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, n;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Tie straight after reset: port 0 first, then port 1
        run_pair(3'd2, 3'd3, 3'd6, 3'd4);
        run_single(0, 3'd5, 3'd3, lat);
        // Repeated identical operands back to back
        run_single(0, 3'd7, 3'd7, lat);
        run_single(0, 3'd7, 3'd7, lat);
        // Port 0 served last, so this tie goes to port 1 first
        run_pair(3'd1, 3'd5, 3'd4, 3'd3);

        // Multiplier never answers: timeout with err and zero result
        stuck = 1'b1;
        run_single(0, 3'd5, 3'd3, lat);
        check("timeout_latency", (lat >= TIMEOUT + 2) && (lat <= TIMEOUT + 6), 1);
        stuck = 1'b0;

        // Reset while waiting on the multiplier
        @(negedge clk);
        push_exp(0, 3'd5, 3'd6);
        bus.a0 = 3'd5; bus.b0 = 3'd6; bus.req0 = 1'b1;
        n = 0;
        while (dbg_state != ST_WAIT && n < 20) begin @(negedge clk); n++; end
        check("reached_wait", dbg_state == ST_WAIT, 1);
        do_reset();
        run_single(1, 3'd3, 3'd3, lat);

        // Zero operand
        run_single(0, 3'd0, 3'd6, lat);
`ifdef MULT_BYPASS_EN
        check("zero_operand_latency", lat <= 2, 1);
`else
        check("zero_operand_latency", lat >= 6, 1);
`endif

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                run_single(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                           3'($urandom_range(0, 7)), lat);
            end else begin
                run_pair(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                         3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
